// File: rtl/bit_serial_substractor_pkg.sv
// Shared definitions for the serial add/sub sequencers.
// FSM state encoding and width limits.
package bit_serial_substractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/bit_serial_substractor_cell.sv
// One-bit full subtractor: d = a - b - bin.
// Purely combinational; the only subtraction logic.
module full_substractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit_serial_substractor.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// Optional signed overflow port: SERIAL_SUB_OVF_EN.
module bit_serial_substractor
  import bit_serial_substractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] d_sr;
  logic [CW-1:0]    count;
  logic             br;
  logic             d;
  logic             bo;
  logic [WIDTH-1:0] dnext;

  full_substractor_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d),
    .bout (bo)
  );

  // new diff bit enters at the MSB, older bits move toward the LSB
  assign dnext = {d, d_sr};

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // sequencer: capture, shift through the cell, latch the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      count      <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            br    <= borrow_in;
            count <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          d_sr  <= dnext[WIDTH-1:1];
          br    <= bo;
          count <= count + 1'b1;
          if (count == LAST) begin
            diff       <= dnext;
            borrow_out <= bo;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= (a_sr[0] != b_sr[0]) && (d != a_sr[0]);
`endif
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_substractor.sv
// Testbench for bit_serial_substractor (WIDTH 8 and 2).
// Arithmetic reference model plus directed literal checks.
module tb_bit_serial_substractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bo;
  logic         ovf;

  logic         start2;
  logic [1:0]   a2;
  logic [1:0]   b2;
  logic         bin2;
  logic         busy2;
  logic         done2;
  logic [1:0]   diff2;
  logic         bo2;
  logic         ovf2;

  int errors = 0;
  int checks = 0;

  bit_serial_substractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .borrow_in  (bin),
    .busy       (busy),
    .done       (done),
`ifdef SERIAL_SUB_OVF_EN
    .ovf        (ovf),
`endif
    .diff       (diff),
    .borrow_out (bo)
  );

  bit_serial_substractor #(.WIDTH(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .a_in       (a2),
    .b_in       (b2),
    .borrow_in  (bin2),
    .busy       (busy2),
    .done       (done2),
`ifdef SERIAL_SUB_OVF_EN
    .ovf        (ovf2),
`endif
    .diff       (diff2),
    .borrow_out (bo2)
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf  = 1'b0;
  assign ovf2 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: m_t = edges since the accepted start (0 = idle)
  int         m_t = 0;
  logic [W-1:0] m_diff = '0;
  logic       m_bo = 1'b0;
  logic       m_ovf = 1'b0;
  logic [W-1:0] p_diff = '0;
  logic       p_bo = 1'b0;
  logic       p_ovf = 1'b0;
  logic [W:0] r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0;
      m_diff = '0;
      m_bo = 1'b0;
      m_ovf = 1'b0;
    end else if (m_t == 0) begin
      if (start === 1'b1) begin
        r = {1'b0, a_in} - {1'b0, b_in} - (W + 1)'(bin);
        p_diff = r[W-1:0];
        p_bo = r[W];
        p_ovf = (a_in[W-1] != b_in[W-1]) && (r[W-1] != a_in[W-1]);
        m_t = 1;
      end
    end else if (m_t == W) begin
      m_diff = p_diff;
      m_bo = p_bo;
      m_ovf = p_ovf;
      m_t = W + 1;
    end else if (m_t == W + 1) begin
      m_t = 0;
    end else begin
      m_t++;
    end
  end

  // compare the WIDTH=8 instance against the model every cycle
  always @(negedge clk) begin
    chk("busy", busy, m_t != 0);
    chk("done", done, m_t == W + 1);
    chk("diff", diff, m_diff);
    chk("borrow_out", bo, m_bo);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", ovf, m_ovf);
`endif
  end

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic c);
    @(negedge clk);
    a_in = a;
    b_in = b;
    bin = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    int n;
    int pulses;
    logic [1:0] e2;
    logic ok;
    rst_n = 1'b0;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    bin = 1'b0;
    start2 = 1'b0;
    a2 = '0;
    b2 = '0;
    bin2 = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_bo", bo, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // 1: 5A - 3C
    go(8'h5A, 8'h3C, 1'b0);
    wait_done(n);
    chk("t1_latency", n, 8);
    chk("t1_diff", diff, 8'h1E);
    chk("t1_bo", bo, 1'b0);
    chk("t1_model", m_diff, 8'h1E);

    // 2: 10 - 20
    go(8'h10, 8'h20, 1'b0);
    wait_done(n);
    chk("t2_diff", diff, 8'hF0);
    chk("t2_bo", bo, 1'b1);
    chk("t2_ovf", ovf, 1'b0);
    chk("t2_model", m_bo, 1'b1);

    // 3: 00 - 00 - 1, busy length
    go(8'h00, 8'h00, 1'b1);
    n = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("t3_busy_cycles", n, 9);
    chk("t3_diff", diff, 8'hFF);
    chk("t3_bo", bo, 1'b1);

    // 4: starts during SHIFT and DONE are ignored
    go(8'hC3, 8'h21, 1'b0);
    repeat (3) @(negedge clk);
    a_in = 8'h01;
    b_in = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    a_in = 8'h77;
    b_in = 8'h99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("t4_extra_done", pulses, 0);
    chk("t4_diff", diff, 8'hA2);
    chk("t4_bo", bo, 1'b0);

    // 5: reset mid-operation, then 80 - 01
    go(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_diff", diff, 8'h00);
    chk("t5_done", done, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("t5_no_done", pulses, 0);
    go(8'h80, 8'h01, 1'b0);
    wait_done(n);
    chk("t5_diff2", diff, 8'h7F);
    chk("t5_bo2", bo, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    chk("t5_ovf", ovf, 1'b1);
`endif

    // random start/operand traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a_in = W'($urandom);
      b_in = W'($urandom);
      bin = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // 6: WIDTH=2 exhaustive
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          a2 = 2'(a);
          b2 = 2'(b);
          bin2 = 1'(c);
          start2 = 1'b1;
          @(negedge clk);
          start2 = 1'b0;
          ok = 1'b0;
          for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done2) begin
              ok = 1'b1;
              break;
            end
          end
          e2 = 2'(a - b - c);
          chk("w2_done", ok, 1'b1);
          chk("w2_diff", diff2, e2);
          chk("w2_bo", bo2, (a - b - c) < 0);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
